// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two pipeline stages.
// Carries upstream/downstream valid-ready plus monitor outputs.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occupancy_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o,
        input  occupancy_o, stall_cnt_o
    );

    modport slave (
        input  in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_ctrl_o, out_data_o,
        output occupancy_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with 2-entry skid buffer,
// flush, bubble control zeroing and a stall-cycle counter.
module pipe_stage_skid #(
    parameter int DATA_W              = 64,
    parameter int CTRL_W              = 4,
    parameter int CNT_W               = 16,
    parameter bit ZERO_DATA_ON_BUBBLE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic stall_cnt_clr_i,
    pipe_stage_skid_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [CNT_W-1:0]  cnt_q;

    logic valid;
    logic in_fire, out_fire;
    logic ld_main_in, ld_main_skid, ld_skid;

    assign valid    = (state_q != EMPTY);
    assign in_fire  = bus.in_valid_i & ready_q;
    assign out_fire = valid & bus.out_ready_i;

    // Next-state and register-load selection; flush overrides all.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    ld_main_in = 1'b1;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    ld_skid = 1'b1;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    ld_main_skid = 1'b1;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // State and registered ready; ready never sees out_ready_i directly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
        end
    end

    // Main/skid payload; control is zeroed whenever the stage goes empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (ld_main_in) begin
                main_data_q <= bus.in_data_i;
            end else if (ld_main_skid) begin
                main_data_q <= skid_data_q;
            end else if (ZERO_DATA_ON_BUBBLE && state_d == EMPTY) begin
                main_data_q <= '0;
            end
            if (state_d == EMPTY) begin
                main_ctrl_q <= '0;
            end else if (ld_main_in) begin
                main_ctrl_q <= bus.in_ctrl_i;
            end else if (ld_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
            end
            if (ld_skid) begin
                skid_data_q <= bus.in_data_i;
                skid_ctrl_q <= bus.in_ctrl_i;
            end
        end
    end

    // Saturating count of stalled cycles; clear wins over increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (stall_cnt_clr_i) begin
            cnt_q <= '0;
        end else if (valid && !bus.out_ready_i && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready_o  = ready_q;
    assign bus.out_valid_o = valid;
    assign bus.out_ctrl_o  = main_ctrl_q;
    assign bus.out_data_o  = main_data_q;
    assign bus.occupancy_o = state_q;
    assign bus.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table
// plus hand sequences for saturation and mid-stream reset.
module tb_pipe_stage_skid;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic clr;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(4), .CNT_W(4)) bus ();

    pipe_stage_skid #(
        .DATA_W(64),
        .CTRL_W(4),
        .CNT_W(4),
        .ZERO_DATA_ON_BUBBLE(1'b0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .stall_cnt_clr_i(clr),
        .bus(bus)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [3:0]  ic;
        logic [63:0] id;
        logic        ordy;
        logic        cl;
        logic        eov;
        logic [3:0]  eoc;
        logic [63:0] eod;
        logic        eir;
        logic [1:0]  eocc;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vecs[26];

    task automatic drive(input logic fl, input logic iv,
                         input logic [3:0] ic, input logic [63:0] id,
                         input logic ordy, input logic cl);
        flush          = fl;
        clr            = cl;
        bus.in_valid_i = iv;
        bus.in_ctrl_i  = iv ? ic : 4'bx;
        bus.in_data_i  = iv ? id : 64'bx;
        bus.out_ready_i = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic ov,
                         input logic [3:0] oc, input logic [63:0] od,
                         input logic ir, input logic [1:0] occ,
                         input logic [3:0] cnt);
        tests++;
        if (bus.out_valid_o !== ov || bus.out_ctrl_o !== oc ||
            bus.out_data_o !== od || bus.in_ready_o !== ir ||
            bus.occupancy_o !== occ || bus.stall_cnt_o !== cnt) begin
            fails++;
            $display("FAIL %s: got ov=%b oc=%h od=%h ir=%b occ=%0d cnt=%0d want ov=%b oc=%h od=%h ir=%b occ=%0d cnt=%0d",
                     nm, bus.out_valid_o, bus.out_ctrl_o, bus.out_data_o,
                     bus.in_ready_o, bus.occupancy_o, bus.stall_cnt_o,
                     ov, oc, od, ir, occ, cnt);
        end
    endtask

    initial begin
        // streaming 0x1..0x8, one cycle latency
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b0, 1'b1, 4'hA, 64'(i + 1), 1'b1, 1'b0,
                        1'b1, 4'hA, 64'(i + 1), 1'b1, 2'd1, 4'd0};
        end
        vecs[8]  = '{0, 0, 4'h0, 64'h0,  1, 0, 0, 4'h0, 64'h8,  1, 2'd0, 4'd0};
        // back-pressure into skid, then drain in order
        vecs[9]  = '{0, 1, 4'h5, 64'h11, 0, 0, 1, 4'h5, 64'h11, 1, 2'd1, 4'd0};
        vecs[10] = '{0, 1, 4'h6, 64'h22, 0, 0, 1, 4'h5, 64'h11, 0, 2'd2, 4'd1};
        vecs[11] = '{0, 1, 4'h7, 64'h33, 0, 0, 1, 4'h5, 64'h11, 0, 2'd2, 4'd2};
        vecs[12] = '{0, 1, 4'h7, 64'h33, 0, 0, 1, 4'h5, 64'h11, 0, 2'd2, 4'd3};
        vecs[13] = '{0, 1, 4'h7, 64'h33, 1, 0, 1, 4'h6, 64'h22, 1, 2'd1, 4'd3};
        vecs[14] = '{0, 1, 4'h7, 64'h33, 1, 0, 1, 4'h7, 64'h33, 1, 2'd1, 4'd3};
        vecs[15] = '{0, 0, 4'h0, 64'h0,  1, 0, 0, 4'h0, 64'h33, 1, 2'd0, 4'd3};
        // flush while FULL with a concurrent push of 0x44
        vecs[16] = '{0, 1, 4'h1, 64'h41, 0, 0, 1, 4'h1, 64'h41, 1, 2'd1, 4'd3};
        vecs[17] = '{0, 1, 4'h2, 64'h42, 0, 0, 1, 4'h1, 64'h41, 0, 2'd2, 4'd4};
        vecs[18] = '{1, 1, 4'h3, 64'h44, 0, 0, 0, 4'h0, 64'h41, 1, 2'd0, 4'd5};
        vecs[19] = '{0, 0, 4'h0, 64'h0,  1, 0, 0, 4'h0, 64'h41, 1, 2'd0, 4'd5};
        // simultaneous fire in ONE
        vecs[20] = '{0, 1, 4'h9, 64'h55, 1, 0, 1, 4'h9, 64'h55, 1, 2'd1, 4'd5};
        vecs[21] = '{0, 1, 4'hB, 64'h66, 1, 0, 1, 4'hB, 64'h66, 1, 2'd1, 4'd5};
        vecs[22] = '{0, 0, 4'h0, 64'h0,  1, 0, 0, 4'h0, 64'h66, 1, 2'd0, 4'd5};
        // flush in ONE with concurrent out_fire and in_fire
        vecs[23] = '{0, 1, 4'h1, 64'h88, 1, 0, 1, 4'h1, 64'h88, 1, 2'd1, 4'd5};
        vecs[24] = '{1, 1, 4'h2, 64'h99, 1, 0, 0, 4'h0, 64'h88, 1, 2'd0, 4'd5};
        // counter clear
        vecs[25] = '{0, 0, 4'h0, 64'h0,  0, 1, 0, 4'h0, 64'h88, 1, 2'd0, 4'd0};

        rst = 1'b1;
        drive(0, 0, 4'h0, 64'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        check("reset", 0, 4'h0, 64'h0, 1, 2'd0, 4'd0);

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ic, vecs[i].id,
                  vecs[i].ordy, vecs[i].cl);
            step();
            check($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eoc,
                  vecs[i].eod, vecs[i].eir, vecs[i].eocc, vecs[i].ecnt);
        end

        // stall counter saturation at 15
        drive(0, 1, 4'hC, 64'hAA, 0, 0);
        step();
        check("sat_push", 1, 4'hC, 64'hAA, 1, 2'd1, 4'd0);
        drive(0, 0, 4'h0, 64'h0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        check("sat_15", 1, 4'hC, 64'hAA, 1, 2'd1, 4'd15);
        drive(0, 0, 4'h0, 64'h0, 0, 1);
        step();
        check("clr_prio", 1, 4'hC, 64'hAA, 1, 2'd1, 4'd0);
        drive(0, 0, 4'h0, 64'h0, 0, 0);
        step();
        check("after_clr", 1, 4'hC, 64'hAA, 1, 2'd1, 4'd1);
        drive(0, 0, 4'h0, 64'h0, 1, 0);
        step();
        check("sat_drain", 0, 4'h0, 64'hAA, 1, 2'd0, 4'd1);

        // reset mid-stream while FULL
        drive(0, 1, 4'h1, 64'hB1, 0, 0);
        step();
        check("rst_fill1", 1, 4'h1, 64'hB1, 1, 2'd1, 4'd1);
        drive(0, 1, 4'h2, 64'hB2, 0, 0);
        step();
        check("rst_fill2", 1, 4'h1, 64'hB1, 0, 2'd2, 4'd2);
        rst = 1'b1;
        drive(0, 1, 4'h3, 64'hB3, 1, 0);
        step();
        rst = 1'b0;
        check("rst_mid", 0, 4'h0, 64'h0, 1, 2'd0, 4'd0);
        drive(0, 1, 4'h7, 64'h77, 1, 0);
        step();
        check("post_rst_77", 1, 4'h7, 64'h77, 1, 2'd1, 4'd0);
        drive(0, 0, 4'h0, 64'h0, 1, 0);
        step();
        check("post_rst_alone", 0, 4'h0, 64'h77, 1, 2'd0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed-field inter-stage pipeline registers (EX/MEM style). It carries a data payload and control bits between two pipeline stages. A valid/ready handshake replaces the global stall input, and a 2-entry skid buffer keeps full throughput with a registered in_ready_o. It adds synchronous flush (bubble insertion), control zeroing on bubbles, and a saturating back-pressure counter for performance monitoring.

Parameters:
DATA_W, 64, payload width (ALU result, store data, rd address etc. packed by the instantiating stage).
CTRL_W, 4, control-bit width (RegWrite/MemtoReg/MemRead/MemWrite style); forced to 0 whenever no valid entry is presented.
CNT_W, 16, width of the stall-cycle counter.
ZERO_DATA_ON_BUBBLE, 0, if 1, out_data_o also reads 0 when out_valid_o=0; if 0, data holds its last value.

Ports:
clk_i  input  1  clock, all state updates on rising edge.
rst_i  input  1  synchronous, active-high reset.
flush_i  input  1  discard all held entries; sampled at the rising edge.
in_valid_i  input  1  upstream entry present.
in_ready_o  output  1  stage can accept an entry; registered.
in_ctrl_i  input  CTRL_W  upstream control bits.
in_data_i  input  DATA_W  upstream payload.
out_valid_o  output  1  entry presented downstream.
out_ready_i  input  1  downstream accepts.
out_ctrl_o  output  CTRL_W  control bits of head entry, 0 when out_valid_o=0.
out_data_o  output  DATA_W  payload of head entry.
occupancy_o  output  2  number of held entries, 0..2.
stall_cnt_clr_i  input  1  clear stall counter.
stall_cnt_o  output  CNT_W  saturating count of cycles with out_valid_o=1 and out_ready_i=0.

Behaviour:
- Storage: main register (drives outputs) and skid register. State is EMPTY (0), ONE (1) or FULL (2); occupancy_o encodes the state.
- Handshakes: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- in_ready_o = (state != FULL) and is a flop output. No combinational path from out_ready_i to in_ready_o.
- out_valid_o = (state != EMPTY). out_* always come from the main register, never from the skid register.
- EMPTY: on in_fire, main <= in and go to ONE.
- ONE:
  - in_fire and out_fire: main <= in, stay in ONE.
  - in_fire only: skid <= in, go to FULL.
  - out_fire only: go to EMPTY.
  - neither: hold.
- FULL: on out_fire, main <= skid and go to ONE. in_fire cannot occur.
- Latency: an entry accepted in EMPTY appears at out_* the next cycle. Throughput is 1 entry/cycle while out_ready_i=1.
- Ordering is strict FIFO: the skid entry is always older than any later input. No entry is duplicated or dropped except by flush or reset.
- Flush: next state is EMPTY. A concurrent in_fire entry is discarded and a concurrent out_fire still counts as consumed. Payload registers may hold stale data; out_ctrl_o reads 0.
- Priority: rst_i > flush_i > normal operation.
- Bubble zeroing: out_ctrl_o = 0 whenever out_valid_o=0. This is registered, not gated combinationally from the state.
- Stall counter: increments when out_valid_o & ~out_ready_i and saturates at 2^CNT_W-1.
  - stall_cnt_clr_i loads 0 and takes priority over increment.
  - flush_i does not clear the counter.
- Reset values: state EMPTY; in_ready_o=1 (first cycle after reset); out_valid_o=0; out_ctrl_o=0; out_data_o=0; skid=0; occupancy_o=0; stall_cnt_o=0.
- Reset mid-operation: all held entries are lost, with no partial handshake effects.
- Inputs are don't-care when in_valid_i=0. X on in_data_i must not propagate while the stage is not accepting.

Test Plan:
- Streaming: out_ready_i=1, push 0x1..0x8 with ctrl=4'hA on back-to-back cycles -> out emits 0x1..0x8, each one cycle after input; in_ready_o stays 1; occupancy_o ≤1; stall_cnt_o=0.
- Back-pressure/skid: push 0x11, 0x22, 0x33 while out_ready_i=0 -> occupancy_o 1 then 2; in_ready_o=0 after 0x22; 0x33 held upstream. Raise out_ready_i -> 0x11, 0x22, 0x33 delivered in order; stall_cnt_o equals stalled cycles.
- Flush while FULL with in_valid_i=1 (0x44) -> next cycle out_valid_o=0, out_ctrl_o=0, occupancy_o=0, in_ready_o=1; 0x44 never emitted.
- Simultaneous fire in ONE: main=0x55, push 0x66 with out_ready_i=1 -> 0x55 consumed, out_data_o=0x66, occupancy_o stays 1.
- Counter: CNT_W=4, hold out_valid_o=1 with out_ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15. Pulse stall_cnt_clr_i together with a stall -> 0.
- Reset mid-stream in FULL -> next cycle all outputs at reset values, in_ready_o=1. The next push 0x77 emerges alone.
